pll_lock_sequencer: RTL and testbench

//  Drives the PLL's reset input and consumes its locked output. Runs in the 74.25 MHz reference domain.

---
 rtl/pll_lock_sequencer.sv | 140 ++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses PLL reset, waits for a stable lock, then releases core reset.
// Optional lock-loss counter output enabled by defining PLL_LOCK_STATUS_EN.
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT  = 742500,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       clk_74a,
  input  logic       reset_n,
  input  logic       pll_locked_raw,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       core_reset_n,
  output logic       ready,
  output logic       fault
`ifdef PLL_LOCK_STATUS_EN
  ,
  output logic [7:0] lock_loss_cnt
`endif
);

  localparam int RW = (RST_CYCLES    > 1) ? $clog2(RST_CYCLES)    : 1;
  localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int TW = (LOCK_TIMEOUT  > 1) ? $clog2(LOCK_TIMEOUT)  : 1;
  localparam int QW = $clog2(MAX_RETRIES + 2);

  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [QW-1:0] RETRY_LIM = QW'(MAX_RETRIES);
  localparam logic [QW-1:0] RETRY_SAT = QW'(MAX_RETRIES + 1);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABILIZE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t          r_state;
  logic [RW-1:0]   r_rst_cnt;
  logic [SW-1:0]   r_stab_cnt;
  logic [TW-1:0]   r_tmo_cnt;
  logic [QW-1:0]   r_retry_cnt;
  logic            r_sync1;
  logic            r_locked_s;
`ifdef PLL_LOCK_STATUS_EN
  logic [7:0]      r_loss_cnt;
  assign lock_loss_cnt = r_loss_cnt;
`endif

  always_ff @(posedge clk_74a) begin
    if (!reset_n) begin
      r_state      <= S_RESET_PLL;
      r_rst_cnt    <= '0;
      r_stab_cnt   <= '0;
      r_tmo_cnt    <= '0;
      r_retry_cnt  <= '0;
      r_sync1      <= 1'b0;
      r_locked_s   <= 1'b0;
      pll_rst      <= 1'b1;
      core_reset_n <= 1'b0;
      ready        <= 1'b0;
      fault        <= 1'b0;
`ifdef PLL_LOCK_STATUS_EN
      r_loss_cnt   <= '0;
`endif
    end else begin
      r_sync1      <= pll_locked_raw;
      r_locked_s   <= r_sync1;
      // Outputs follow the state one cycle later so they are glitch-free flops.
      pll_rst      <= (r_state == S_RESET_PLL);
      core_reset_n <= (r_state == S_RUN);
      ready        <= (r_state == S_RUN);
      fault        <= (r_state == S_FAULT);

      if (relock_req) begin
        r_state     <= S_RESET_PLL;
        r_rst_cnt   <= '0;
        r_retry_cnt <= '0;
      end else begin
        case (r_state)
          S_RESET_PLL: begin
            if (r_rst_cnt == RST_LAST) begin
              r_state   <= S_WAIT_LOCK;
              r_tmo_cnt <= '0;
            end else begin
              r_rst_cnt <= r_rst_cnt + 1'b1;
            end
          end
          S_WAIT_LOCK: begin
            if (r_locked_s) begin
              r_state    <= S_STABILIZE;
              r_stab_cnt <= '0;
            end else if (r_tmo_cnt == TMO_LAST) begin
              if (r_retry_cnt != RETRY_SAT) r_retry_cnt <= r_retry_cnt + 1'b1;
              // This failure's number is r_retry_cnt+1; beyond MAX_RETRIES we give up.
              if (r_retry_cnt >= RETRY_LIM) begin
                r_state <= S_FAULT;
              end else begin
                r_state   <= S_RESET_PLL;
                r_rst_cnt <= '0;
              end
            end else begin
              r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
          end
          S_STABILIZE: begin
            if (!r_locked_s) begin
              r_state   <= S_WAIT_LOCK;
              r_tmo_cnt <= '0;
            end else if (r_stab_cnt == STAB_LAST) begin
              r_state     <= S_RUN;
              r_retry_cnt <= '0;
            end else begin
              r_stab_cnt <= r_stab_cnt + 1'b1;
            end
          end
          S_RUN: begin
            if (!r_locked_s) begin
              r_state   <= S_RESET_PLL;
              r_rst_cnt <= '0;
`ifdef PLL_LOCK_STATUS_EN
              if (r_loss_cnt != 8'hFF) r_loss_cnt <= r_loss_cnt + 1'b1;
`endif
            end
          end
          S_FAULT: r_state <= S_FAULT;
          default: begin
            r_state   <= S_RESET_PLL;
            r_rst_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed bring-up scenarios then random lock/relock/reset traffic,
// every cycle compared against a phase/elapsed-time reference model.
module tb_pll_lock_sequencer;

  localparam int RST_C = 4;
  localparam int STB_C = 8;
  localparam int TMO_C = 32;
  localparam int RTY_C = 2;

  logic clk_74a = 1'b0;
  logic reset_n, pll_locked_raw, relock_req;
  logic pll_rst, core_reset_n, ready, fault;
`ifdef PLL_LOCK_STATUS_EN
  logic [7:0] lock_loss_cnt;
`endif

  always #5 clk_74a = ~clk_74a;

  pll_lock_sequencer #(
    .RST_CYCLES(RST_C), .STABLE_CYCLES(STB_C), .LOCK_TIMEOUT(TMO_C), .MAX_RETRIES(RTY_C)
  ) dut (
    .clk_74a       (clk_74a),
    .reset_n       (reset_n),
    .pll_locked_raw(pll_locked_raw),
    .relock_req    (relock_req),
    .pll_rst       (pll_rst),
    .core_reset_n  (core_reset_n),
    .ready         (ready),
    .fault         (fault)
`ifdef PLL_LOCK_STATUS_EN
    ,
    .lock_loss_cnt (lock_loss_cnt)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase + entry time, lock seen two sampled edges late.
  localparam int PH_PULSE = 0, PH_WAIT = 1, PH_SETTLE = 2, PH_UP = 3, PH_DEAD = 4;
  int  ph, t_ent, fails, cyc, loss;
  bit  m_valid = 1'b0;
  bit  hist[$];
  bit  e_rst, e_core, e_ready, e_fault;

  function automatic void enter(input int p);
    ph    = p;
    t_ent = cyc;
  endfunction

  function automatic void model_edge();
    bit ls;
    int el;
    if (!reset_n) begin
      e_rst = 1; e_core = 0; e_ready = 0; e_fault = 0;
      enter(PH_PULSE);
      fails = 0; loss = 0; m_valid = 1'b1;
      hist.delete(); hist.push_back(1'b0); hist.push_back(1'b0);
    end else begin
      ls = hist[hist.size()-2];
      hist.push_back(pll_locked_raw);
      if (hist.size() > 4) void'(hist.pop_front());
      e_rst   = (ph == PH_PULSE);
      e_core  = (ph == PH_UP);
      e_ready = (ph == PH_UP);
      e_fault = (ph == PH_DEAD);
      el = cyc - t_ent;
      if (relock_req) begin
        enter(PH_PULSE); fails = 0;
      end else if (ph == PH_PULSE) begin
        if (el == RST_C) enter(PH_WAIT);
      end else if (ph == PH_WAIT) begin
        if (ls) enter(PH_SETTLE);
        else if (el == TMO_C) begin
          fails++;
          enter(fails > RTY_C ? PH_DEAD : PH_PULSE);
        end
      end else if (ph == PH_SETTLE) begin
        if (!ls) enter(PH_WAIT);
        else if (el == STB_C) begin enter(PH_UP); fails = 0; end
      end else if (ph == PH_UP) begin
        if (!ls) begin enter(PH_PULSE); if (loss < 255) loss++; end
      end
    end
    cyc++;
  endfunction

  task automatic tick();
    @(posedge clk_74a);
    model_edge();
    @(negedge clk_74a);
    if (m_valid) begin
      chk("pll_rst", pll_rst, e_rst);
      chk("core_reset_n", core_reset_n, e_core);
      chk("ready", ready, e_ready);
      chk("fault", fault, e_fault);
`ifdef PLL_LOCK_STATUS_EN
      chk("lock_loss_cnt", lock_loss_cnt, loss);
`endif
    end
  endtask

  task automatic pulse_relock();
    relock_req = 1'b1; tick(); relock_req = 1'b0;
  endtask

  task automatic wait_rst_low(input string tag);
    int k = 0;
    while (pll_rst !== 1'b0 && k < 50) begin tick(); k++; end
    if (pll_rst !== 1'b0) chk(tag, 0, 1);
  endtask

  initial begin
    int cnt, k, rl;
    reset_n = 1'b0; pll_locked_raw = 1'b0; relock_req = 1'b0;
    cyc = 0;
    @(negedge clk_74a);

    // T1: bring-up
    repeat (3) tick();
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_core", core_reset_n, 0);
    chk("rst_fault", fault, 0);
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (pll_rst === 1'b1) cnt++; end
    chk("t1_rst_width", cnt, RST_C);
    pll_locked_raw = 1'b1;
    k = 0;
    while (core_reset_n !== 1'b1 && k < 40) begin tick(); k++; end
    chk("t1_release_latency", k - 1, 2 + STB_C + 1);
    chk("t1_ready", ready, 1);

    // T5: loss of lock in RUN
    pll_locked_raw = 1'b0;
    k = 0;
    while (ready !== 1'b0 && k < 10) begin tick(); k++; end
    chk("t5_drop_within_3", (k - 1) <= 3, 1);
    chk("t5_core", core_reset_n, 0);
    tick(); tick();
    pll_locked_raw = 1'b1;
    k = 0;
    while (core_reset_n !== 1'b1 && k < 60) begin tick(); k++; end
    chk("t5_recovered", core_reset_n, 1);

    // T2: glitch during STABILIZE
    pulse_relock();
    wait_rst_low("t2_rst_timeout");
    repeat (4) tick();
    pll_locked_raw = 1'b0; tick(); pll_locked_raw = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (pll_rst === 1'b1 || core_reset_n === 1'b1) cnt++; end
    chk("t2_no_pulse_no_release", cnt, 0);
    k = 0;
    while (ready !== 1'b1 && k < 40) begin tick(); k++; end
    chk("t2_ready", ready, 1);

    // T3: timeouts into FAULT
    pll_locked_raw = 1'b0;
    repeat (200) tick();
    chk("t3_fault", fault, 1);
    chk("t3_pll_rst", pll_rst, 0);
    chk("t3_core", core_reset_n, 0);

    // T4: recovery from FAULT
    pll_locked_raw = 1'b1;
    pulse_relock();
    tick();
    chk("t4_fault_clear", fault, 0);
    repeat (30) tick();
    chk("t4_ready", ready, 1);

    // T6: reset mid-STABILIZE
    pulse_relock();
    wait_rst_low("t6_rst_timeout");
    repeat (6) tick();
    reset_n = 1'b0; tick();
    chk("t6_pll_rst", pll_rst, 1);
    chk("t6_core", core_reset_n, 0);
    chk("t6_fault", fault, 0);
    reset_n = 1'b1;

    // Random traffic
    rl = 0;
    for (int i = 0; i < 4000; i++) begin
      if (rl == 0) begin
        pll_locked_raw = ~pll_locked_raw;
        if (pll_locked_raw) rl = $urandom_range(1, 40);
        else if ($urandom_range(0, 9) < 7) rl = $urandom_range(1, 3);
        else rl = $urandom_range(20, 120);
      end
      rl--;
      relock_req = ($urandom_range(0, 79) == 0);
      reset_n    = ($urandom_range(0, 399) != 0);
      tick();
    end
    relock_req = 1'b0; reset_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
